addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
Parametrised, multi-lane, pipelined arithmetic/logic unit and the successor to the fixed 8-bit registered add/sub block. Each lane computes ADD, SUB, AND or OR on two WIDTH-bit operands. Results carry a (WIDTH+1)-bit carry/borrow extension and an optional saturation mode. The unit sits between a producer and a consumer under valid/ready flow control, with full throughput and backpressure support, and keeps an overflow event counter.

Parameters:
WIDTH, 8, operand width per lane (>=2)
LANES, 2, number of independent lanes sharing one op and handshake (>=1)
PIPE_STAGES, 2, register stages from accepted input to result (>=1)
SATURATE, 0, 1 = clamp ADD/SUB results instead of exposing carry/borrow

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat this cycle
op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR; applies to all lanes
a  in  LANES*WIDTH  operand A; lane i = bits [i*WIDTH +: WIDTH]
b  in  LANES*WIDTH  operand B; same packing as a
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result
result  out  LANES*(WIDTH+1)  lane i = bits [i*(WIDTH+1) +: WIDTH+1]
ovf  out  LANES  per-lane carry/borrow/saturation flag, aligned with result
ovf_count  out  16  number of accepted output beats with any ovf bit set; saturates at 16'hFFFF

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, result, ovf, out_valid and ovf_count go to 0. in_valid is ignored while rst_n is low. After release, the pipeline is empty, so in_ready=1.
- Transfer rules:
  - Input beat accepted when in_valid && in_ready on a clock edge.
  - Output beat consumed when out_valid && out_ready.
- Elastic pipeline:
  - Stage k may load when its valid bit is 0 or stage k+1 loads or drains that cycle. For the last stage, draining means out_ready.
  - in_ready = ~v[0] | (stage 0 advances this cycle). This is combinational from the valid bits and out_ready; there is no path from in_valid to in_ready.
  - No beat is dropped or duplicated. Order is preserved.
- Timing:
  - Latency: a beat accepted at edge N appears with out_valid=1 after edge N+PIPE_STAGES-1. With PIPE_STAGES=1 it is visible in the cycle following acceptance.
  - Throughput: 1 beat/cycle while out_ready=1.
- Stall: while out_valid && !out_ready, result, ovf and out_valid hold stable. Upstream stages fill, then in_ready drops.
- Compute happens in stage 0; later stages are pure delay registers carrying result, ovf and valid.
- Per-lane arithmetic (unsigned operands), SATURATE=0:
  - ADD: result = {1'b0,a}+{1'b0,b}; ovf = result[WIDTH].
  - SUB: result = ({1'b0,a}-{1'b0,b}) mod 2^(WIDTH+1); ovf = borrow (a<b) = result[WIDTH].
- Per-lane arithmetic, SATURATE=1:
  - ADD: on carry, result = {1'b0, all ones}, ovf=1.
  - SUB: on borrow, result = 0, ovf=1.
  - Otherwise the same as SATURATE=0 with result[WIDTH]=0.
- AND/OR: result = {1'b0, a op b}; ovf=0 in both modes.
- Lanes are fully independent; there is no carry between lanes.
- ovf_count:
  - Increments by 1 on each consumed output beat with |ovf=1.
  - Holds at 16'hFFFF.
  - Cleared only by reset.
- Simultaneous accept and consume on a full pipeline is legal and must sustain full rate.
- Reset mid-operation discards all in-flight beats immediately. No partial beat may appear after release.

Test Plan:
- Defaults, ADD, lane0 a=200 b=100, lane1 a=3 b=4, out_ready=1 -> after 2 edges out_valid=1; lane0 result=9'h12C ovf=1; lane1 result=9'h007 ovf=0; ovf_count=1 after consume.
- SATURATE=1, same stimulus -> lane0 result=9'h0FF ovf=1; lane1 9'h007. Then SUB lane0 a=5 b=10 -> result=9'h000 ovf=1. With SATURATE=0 the same SUB gives 9'h1FB ovf=1.
- AND/OR, a=8'hF0 b=8'h3C -> AND 9'h030, OR 9'h0FC, ovf=0, counter unchanged.
- Backpressure:
  - Stimulus: stream 10 beats (ADD, a=i, b=i) with out_ready toggled by a random 50% pattern.
  - Check results 2*i arrive in order with no loss or duplication.
  - Check result stays stable while stalled.
  - Check in_ready=0 within 2 cycles of sustained out_ready=0 with PIPE_STAGES=2.
- Throughput: PIPE_STAGES=1 and 3, 20 back-to-back beats, out_ready=1 -> in_ready stays 1 and out_valid is continuous for 20 cycles after the latency fill.
- Reset: assert rst_n=0 with 2 beats in flight -> out_valid, result and ovf_count read 0 immediately. After release there is no output until a new beat is accepted. Also: force 65 536 overflow beats -> ovf_count holds at 16'hFFFF.

Source files
------------

// File: rtl/addsub_pipe.sv
// Multi-lane pipelined ADD/SUB/AND/OR unit with valid/ready flow control,
// optional saturation and a saturating overflow-beat counter.
module addsub_pipe #(
  parameter int WIDTH       = 8,
  parameter int LANES       = 2,
  parameter int PIPE_STAGES = 2,
  parameter bit SATURATE    = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   op,
  input  logic [LANES*WIDTH-1:0]       a,
  input  logic [LANES*WIDTH-1:0]       b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*(WIDTH+1)-1:0]   result,
  output logic [LANES-1:0]             ovf,
  output logic [15:0]                  ovf_count
);

  localparam int RW = LANES * (WIDTH + 1);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  logic [RW-1:0]          w_res;
  logic [LANES-1:0]       w_ovf;
  logic [WIDTH-1:0]       w_a;
  logic [WIDTH-1:0]       w_b;
  logic [WIDTH:0]         w_sum;
  logic [WIDTH:0]         w_dif;
  logic                   w_room;
  logic [PIPE_STAGES-1:0] w_load;

  logic [PIPE_STAGES-1:0] r_valid;
  logic [RW-1:0]          r_res [PIPE_STAGES];
  logic [LANES-1:0]       r_ovf [PIPE_STAGES];
  logic [15:0]            r_ovf_count;

  always_comb begin : compute
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    w_res = '0;
    w_ovf = '0;
    w_a   = '0;
    w_b   = '0;
    w_sum = '0;
    w_dif = '0;
    for (int i = 0; i < LANES; i++) begin
      w_a   = a[i*WIDTH +: WIDTH];
      w_b   = b[i*WIDTH +: WIDTH];
      w_sum = {1'b0, w_a} + {1'b0, w_b};
      w_dif = {1'b0, w_a} - {1'b0, w_b};
      case (op)
        OP_ADD: begin
          w_ovf[i] = w_sum[WIDTH];
          if (SATURATE && w_sum[WIDTH]) w_res[i*(WIDTH+1) +: WIDTH+1] = {1'b0, {WIDTH{1'b1}}};
          else                          w_res[i*(WIDTH+1) +: WIDTH+1] = w_sum;
        end
        OP_SUB: begin
          // The top bit of the widened difference is exactly the borrow (a < b).
          w_ovf[i] = w_dif[WIDTH];
          if (SATURATE && w_dif[WIDTH]) w_res[i*(WIDTH+1) +: WIDTH+1] = '0;
          else                          w_res[i*(WIDTH+1) +: WIDTH+1] = w_dif;
        end
        OP_AND:  w_res[i*(WIDTH+1) +: WIDTH+1] = {1'b0, w_a & w_b};
        default: w_res[i*(WIDTH+1) +: WIDTH+1] = {1'b0, w_a | w_b};
      endcase
    end
  end

  // A stage may load when it, or any stage after it, has a free slot, or the consumer drains the last stage.
  always_comb begin : load_enable
    // NOTE: blocking '=' is right in combinational code: w_room must carry its updated value to the next iteration.
    w_room = out_ready;
    w_load = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      w_room    = w_room | ~r_valid[k];
      w_load[k] = w_room;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      // NOTE: data registers are reset as well, because result and ovf must read 0 while reset is held.
      for (int k = 0; k < PIPE_STAGES; k++) begin
        r_res[k] <= '0;
        r_ovf[k] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= in_valid;
        r_res[0]   <= w_res;
        r_ovf[0]   <= w_ovf;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_res[k]   <= r_res[k-1];
          r_ovf[k]   <= r_ovf[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (r_valid[PIPE_STAGES-1] && out_ready && (|r_ovf[PIPE_STAGES-1])
                 && (r_ovf_count != 16'hFFFF)) begin
      r_ovf_count <= r_ovf_count + 16'd1;
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_valid[PIPE_STAGES-1];
  assign result    = r_res[PIPE_STAGES-1];
  assign ovf       = r_ovf[PIPE_STAGES-1];
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: vector table, scoreboard monitor and
// directed sequences for backpressure, throughput, counter saturation and reset.
module tb_addsub_pipe;

  localparam int W  = 8;
  localparam int L  = 2;
  localparam int RW = L * (W + 1);

  typedef struct {
    logic [1:0]    op;
    logic [15:0]   a;
    logic [15:0]   b;
    logic [RW-1:0] res;
    logic [1:0]    ovf;
    logic [RW-1:0] sres;
    logic [1:0]    sovf;
  } vec_t;

  logic clk, rst_n, in_valid, out_ready;
  logic [1:0]  op;
  logic [15:0] a, b;

  logic          ir0, ov0, ir_s, ov_s, ir_p1, ov_p1, ir_p3, ov_p3;
  logic [RW-1:0] res0, res_s, res_p1, res_p3;
  logic [1:0]    ovf0, ovf_s, ovf_p1, ovf_p3;
  logic [15:0]   cnt0, cnt_s, cnt_p1, cnt_p3;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          rx_cnt   = 0;
  logic [15:0] exp_cnt  = '0;
  logic [19:0] sb_q [$];
  logic [19:0] sb_exp;

  addsub_pipe #(.WIDTH(W), .LANES(L), .PIPE_STAGES(2), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .op(op), .a(a), .b(b),
    .out_valid(ov0), .out_ready(out_ready), .result(res0), .ovf(ovf0), .ovf_count(cnt0));

  addsub_pipe #(.WIDTH(W), .LANES(L), .PIPE_STAGES(2), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s), .op(op), .a(a), .b(b),
    .out_valid(ov_s), .out_ready(out_ready), .result(res_s), .ovf(ovf_s), .ovf_count(cnt_s));

  addsub_pipe #(.WIDTH(W), .LANES(L), .PIPE_STAGES(1), .SATURATE(1'b0)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_p1), .op(op), .a(a), .b(b),
    .out_valid(ov_p1), .out_ready(out_ready), .result(res_p1), .ovf(ovf_p1), .ovf_count(cnt_p1));

  addsub_pipe #(.WIDTH(W), .LANES(L), .PIPE_STAGES(3), .SATURATE(1'b0)) dut_p3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_p3), .op(op), .a(a), .b(b),
    .out_valid(ov_p3), .out_ready(out_ready), .result(res_p3), .ovf(ovf_p3), .ovf_count(cnt_p3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference for one lane: {ovf, 9-bit result}, written from the arithmetic definition.
  function automatic logic [9:0] lane_ref(input logic [1:0] o, input int x, input int y, input bit sat);
    case (o)
      2'b00: begin
        if (x + y > 255) return sat ? 10'h2FF : {1'b1, 9'(x + y)};
        return {1'b0, 9'(x + y)};
      end
      2'b01: begin
        if (x < y) return sat ? 10'h200 : {1'b1, 9'(x - y + 512)};
        return {1'b0, 9'(x - y)};
      end
      2'b10:   return {2'b00, 8'(x & y)};
      default: return {2'b00, 8'(x | y)};
    endcase
  endfunction

  function automatic logic [19:0] model(input logic [1:0] o, input logic [15:0] x,
                                        input logic [15:0] y, input bit sat);
    logic [RW-1:0] r;
    logic [1:0]    f;
    logic [9:0]    l;
    for (int k = 0; k < L; k++) begin
      l = lane_ref(o, int'(x[k*W +: W]), int'(y[k*W +: W]), sat);
      r[k*(W+1) +: W+1] = l[8:0];
      f[k] = l[9];
    end
    return {f, r};
  endfunction

  task automatic wait_out0(input int max_cyc);
    int n = 0;
    while (!ov0 && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_out_valid", ov0, 1);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb_q.size() > 0 && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  // Scoreboard monitor on dut0: push at accept, pop and compare at consume.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt = '0;
    end else begin
      if (ov0 && out_ready) begin
        check("sb_avail", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          sb_exp = sb_q.pop_front();
          check("sb_beat", {ovf0, res0}, sb_exp);
          rx_cnt++;
          if (sb_exp[19:18] != 2'b00 && exp_cnt != 16'hFFFF) exp_cnt++;
        end
      end
      if (in_valid && ir0) sb_q.push_back(model(op, a, b, 1'b0));
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [7];
    logic [15:0] tp_a [20];
    logic [15:0] tp_b [20];
    logic [1:0]  tp_op [20];
    logic [19:0] tp_exp [20];
    logic [15:0] tbl_cnt;
    logic [19:0] held;
    logic        acc, stalled;
    int          i, rx_start;

    tbl[0] = '{2'b00, {8'd3,   8'd200}, {8'd4,   8'd100}, {9'h007, 9'h12C}, 2'b01, {9'h007, 9'h0FF}, 2'b01};
    tbl[1] = '{2'b01, {8'd10,  8'd5},   {8'd5,   8'd10},  {9'h005, 9'h1FB}, 2'b01, {9'h005, 9'h000}, 2'b01};
    tbl[2] = '{2'b10, {8'hFF,  8'hF0},  {8'h00,  8'h3C},  {9'h000, 9'h030}, 2'b00, {9'h000, 9'h030}, 2'b00};
    tbl[3] = '{2'b11, {8'h0F,  8'hF0},  {8'hF0,  8'h3C},  {9'h0FF, 9'h0FC}, 2'b00, {9'h0FF, 9'h0FC}, 2'b00};
    tbl[4] = '{2'b01, {8'd255, 8'd0},   {8'd255, 8'd255}, {9'h000, 9'h101}, 2'b01, {9'h000, 9'h000}, 2'b01};
    tbl[5] = '{2'b00, {8'd128, 8'd255}, {8'd128, 8'd1},   {9'h100, 9'h100}, 2'b11, {9'h0FF, 9'h0FF}, 2'b11};
    tbl[6] = '{2'b00, {8'd127, 8'd255}, {8'd128, 8'd0},   {9'h0FF, 9'h0FF}, 2'b00, {9'h0FF, 9'h0FF}, 2'b00};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", ov0, 0);
    check("rst_result", res0, 0);
    check("rst_ovf_count", cnt0, 0);
    check("rst_in_ready", ir0, 1);

    // Vector table: one beat at a time, exact latency, both saturation modes.
    tbl_cnt   = '0;
    out_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      @(posedge clk); #1;
      op = tbl[v].op; a = tbl[v].a; b = tbl[v].b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("tbl_latency_early", ov0, 0);
      @(posedge clk); #1;
      check("tbl_out_valid", ov0, 1);
      check("tbl_result", res0, tbl[v].res);
      check("tbl_ovf", ovf0, tbl[v].ovf);
      check("tbl_sat_result", res_s, tbl[v].sres);
      check("tbl_sat_ovf", ovf_s, tbl[v].sovf);
      if (tbl[v].ovf != 2'b00) tbl_cnt++;
      @(posedge clk); #1;
      check("tbl_ovf_count", cnt0, tbl_cnt);
      check("tbl_sat_ovf_count", cnt_s, tbl_cnt);
    end

    // Throughput: 20 back-to-back beats into the 1- and 3-stage units.
    repeat (5) @(posedge clk);
    for (int t = 0; t < 20; t++) begin
      tp_a[t]   = 16'($urandom);
      tp_b[t]   = 16'($urandom);
      tp_op[t]  = 2'($urandom_range(0, 3));
      tp_exp[t] = model(tp_op[t], tp_a[t], tp_b[t], 1'b0);
    end
    for (int t = 0; t < 25; t++) begin
      @(posedge clk); #1;
      if (t < 20) begin
        in_valid = 1'b1; op = tp_op[t]; a = tp_a[t]; b = tp_b[t];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("tp_in_ready_p1", ir_p1, 1);
      check("tp_in_ready_p3", ir_p3, 1);
      check("tp_valid_p1", ov_p1, (t >= 1 && t <= 20));
      check("tp_valid_p3", ov_p3, (t >= 3 && t <= 22));
      if (t >= 1 && t <= 20) check("tp_data_p1", {ovf_p1, res_p1}, tp_exp[t-1]);
      if (t >= 3 && t <= 22) check("tp_data_p3", {ovf_p3, res_p3}, tp_exp[t-3]);
    end
    repeat (3) @(posedge clk); #1;
    check("tp_count_dut0", cnt0, exp_cnt);
    check("tp_count_p1", cnt_p1, exp_cnt);
    check("tp_count_p3", cnt_p3, exp_cnt);
    check("tp_sb_empty", sb_q.size(), 0);

    // Backpressure: 10 beats a=b=i against a random out_ready pattern.
    rx_start = rx_cnt;
    i = 0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 300 && i < 10; cyc++) begin
      in_valid  = 1'b1;
      op        = 2'b00;
      a         = {i[7:0], i[7:0]};
      b         = {i[7:0], i[7:0]};
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      acc     = ir0;
      stalled = ov0 && !out_ready;
      held    = {ovf0, res0};
      @(posedge clk); #1;
      if (stalled) begin
        check("bp_hold_data", {ovf0, res0}, held);
        check("bp_hold_valid", ov0, 1);
      end
      if (acc) i++;
    end
    check("bp_all_sent", i, 10);
    drain(40);
    check("bp_rx_count", rx_cnt - rx_start, 10);

    // Sustained stall from empty: in_ready must drop after two accepts.
    out_ready = 1'b0; in_valid = 1'b1; op = 2'b00; a = {8'd7, 8'd9}; b = {8'd1, 8'd2};
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_in_ready_drop", ir0, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_stall_valid", ov0, 1);
    check("bp_stall_ready", ir0, 0);
    drain(20);

    // Counter saturation: 65536 overflowing beats at full rate.
    op = 2'b00; a = {8'd255, 8'd255}; b = {8'd1, 8'd1}; out_ready = 1'b1; in_valid = 1'b1;
    repeat (1000) @(posedge clk);
    #1 check("cnt_mid", cnt0, exp_cnt);
    repeat (64536) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("cnt_saturated", cnt0, 16'hFFFF);
    check("cnt_model", cnt0, exp_cnt);

    // Reset with two beats in flight.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; a = {8'd1, 8'd2}; b = {8'd3, 8'd4};
    @(posedge clk); #1;
    a = {8'd5, 8'd6};
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_pre_valid", ov0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", ov0, 0);
    check("rst_async_result", res0, 0);
    check("rst_async_ovf", ovf0, 0);
    check("rst_async_count", cnt0, 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_ignore_in", ov0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      check("rst_no_ghost", ov0, 0);
    end
    check("rst_in_ready", ir0, 1);
    op = 2'b00; a = {8'd20, 8'd10}; b = {8'd30, 8'd20}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out0(5);
    check("rst_new_result", res0, {9'h032, 9'h01E});
    check("rst_new_ovf", ovf0, 0);
    @(posedge clk); #1;
    check("rst_new_count", cnt0, 0);
    check("end_sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
